// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the CPU MEM stage and the
//   debug/program-loader master. One grant per cycle (round-robin on ties),
//   misaligned or undefined accesses are granted but never reach memory, and
//   the winner gets a registered response one cycle after its grant. The
//   loader may hold the port with dbg_lock for at most LOCK_MAX consecutive
//   grant cycles, counting the cycle that took the lock.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_req/we/funct3/addr/wdata  CPU request (we=1 store, 0 load)
//   cpu_gnt                       combinational accept
//   cpu_rvalid/err/rdata          registered response (cycle after grant)
//   dbg_*                         same set for the loader, plus dbg_lock
//   mem_wr/rd/addr/wdata/funct3   memory command (zero when nothing granted)
//   mem_rdata                     combinational memory read data
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_funct3,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata
);

  localparam int                LCNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_MAX);
  localparam logic              CPU      = 1'b0;
  localparam logic              DBG      = 1'b1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              lock_tmo;

  logic              cpu_rvalid_q, cpu_rvalid_d, cpu_err_q, cpu_err_d;
  logic              dbg_rvalid_q, dbg_rvalid_d, dbg_err_q, dbg_err_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;

  logic              cpu_legal, dbg_legal;

  // funct3 0/1/2 = byte/half/word, 4/5 = unsigned byte/half (loads only).
  function automatic logic access_legal(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    case (f3)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~a[0];
      3'd2:    ok = (a == 2'b00);
      3'd4:    ok = ~we;
      3'd5:    ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign cpu_legal = access_legal(cpu_we, cpu_funct3, cpu_addr[1:0]);
  assign dbg_legal = access_legal(dbg_we, dbg_funct3, dbg_addr[1:0]);

  // Arbitration / lock FSM
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    lcnt_d   = lcnt_q;
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    lock_tmo = 1'b0;
    unique case (state_q)
      ARB: begin
        if (cpu_req && dbg_req) begin
          cpu_gnt = (last_q == DBG);
          dbg_gnt = (last_q == CPU);
        end else begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req;
        end
        // With LOCK_MAX == 1 the entry cycle already uses the whole budget,
        // so the lock is never taken.
        if (dbg_gnt && dbg_lock && (LOCK_MAX > 1)) begin
          state_d = LOCKED;
          lcnt_d  = LCNT_W'(1);
        end
      end
      LOCKED: begin
        dbg_gnt  = dbg_req;
        lcnt_d   = lcnt_q + LCNT_W'(1);
        lock_tmo = (lcnt_d == LCNT_MAX);
        if (!dbg_lock || lock_tmo) begin
          state_d = ARB;
          lcnt_d  = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (cpu_gnt)  last_d = CPU;
    if (dbg_gnt)  last_d = DBG;
    // Timeout leaves the CPU as the favoured side on the next tie even if
    // the loader had no request in its final locked cycle.
    if (lock_tmo) last_d = DBG;
  end

  // Memory command: winner's payload, enables masked by legality.
  always_comb begin
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (cpu_gnt) begin
      mem_wr     = cpu_we & cpu_legal;
      mem_rd     = ~cpu_we & cpu_legal;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end else if (dbg_gnt) begin
      mem_wr     = dbg_we & dbg_legal;
      mem_rd     = ~dbg_we & dbg_legal;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = dbg_funct3;
    end
  end

  // Responses: stores and rejected accesses return zero data.
  always_comb begin
    cpu_rvalid_d = cpu_gnt;
    cpu_err_d    = cpu_gnt & ~cpu_legal;
    cpu_rdata_d  = (cpu_gnt & cpu_legal & ~cpu_we) ? mem_rdata : 32'h0;
    dbg_rvalid_d = dbg_gnt;
    dbg_err_d    = dbg_gnt & ~dbg_legal;
    dbg_rdata_d  = (dbg_gnt & dbg_legal & ~dbg_we) ? mem_rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      last_q       <= DBG;
      lcnt_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      lcnt_q       <= lcnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_err_q    <= dbg_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed scenarios followed by random traffic. A byte-array reference
//   model predicts grants, memory command and responses; expected responses
//   go into a queue that an independent monitor drains when rvalid shows up.
//   The memory behind the port is a separate word-organised model.
module tb_dmem_port_arbiter;
  localparam int ADDR_W   = 12;
  localparam int LOCK_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [2:0]        cpu_funct3 = 0, dbg_funct3 = 0;
  logic [ADDR_W-1:0] cpu_addr = 0, dbg_addr = 0;
  logic [31:0]       cpu_wdata = 0, dbg_wdata = 0;
  logic              cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0]       cpu_rdata, dbg_rdata;
  logic              mem_wr, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [2:0]        mem_funct3;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_funct3(dbg_funct3), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory behind the port (word organised) ----------------
  logic [31:0] env_mem [0:1023] = '{default: 32'h0};
  logic [31:0] env_word, env_sh;

  always_comb begin
    env_word  = env_mem[mem_addr[11:2]];
    env_sh    = env_word >> {mem_addr[1:0], 3'b000};
    mem_rdata = 32'h0;
    case (mem_funct3)
      3'd0: mem_rdata = {{24{env_sh[7]}}, env_sh[7:0]};
      3'd1: mem_rdata = {{16{env_sh[15]}}, env_sh[15:0]};
      3'd2: mem_rdata = env_word;
      3'd4: mem_rdata = {24'h0, env_sh[7:0]};
      3'd5: mem_rdata = {16'h0, env_sh[15:0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr) begin
      case (mem_funct3)
        3'd0: env_mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        3'd1: env_mem[mem_addr[11:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: env_mem[mem_addr[11:2]] <= mem_wdata;
      endcase
    end
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { bit req; bit we; bit [2:0] f3; bit [11:0] addr; bit [31:0] wd; } rq_t;
  typedef struct { int cyc; bit side; bit err; bit [31:0] data; } resp_t;

  resp_t exp_q[$];

  // ---------------- reference model ----------------
  bit [7:0] ref_mem [0:4095];
  bit       m_last = 1'b1;   // 1 = loader had the last grant
  bit       m_locked = 1'b0;
  int       m_run = 0;       // grants consumed by the current lock
  rq_t      cpu_p, dbg_p;
  bit       lock_in = 1'b0;
  bit [7:0] hc = 0, hd = 0;  // recent grant history, newest in bit 0

  function automatic bit ref_legal(bit we, bit [2:0] f3, bit [11:0] addr);
    int size = 1 << f3[1:0];
    bit ok_op = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    return ok_op && (int'(addr) % size == 0);
  endfunction

  function automatic bit [31:0] ref_load(bit [2:0] f3, bit [11:0] addr);
    int n = 1 << f3[1:0];
    bit [31:0] v = 0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[int'(addr) + i]) << (8 * i);
    if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic ref_store(bit [2:0] f3, bit [11:0] addr, bit [31:0] wd);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
  endtask

  task automatic model_cycle();
    bit gc = 0, gd = 0, tmo = 0, g, leg;
    rq_t w;
    resp_t e;
    if (m_locked) begin
      gd = dbg_p.req;
      m_run++;
      tmo = (m_run == LOCK_MAX);
      if (!lock_in || tmo) m_locked = 0;
    end else begin
      if (cpu_p.req && dbg_p.req) begin gc = m_last; gd = !m_last; end
      else begin gc = cpu_p.req; gd = dbg_p.req; end
      if (gd && lock_in && LOCK_MAX > 1) begin m_locked = 1; m_run = 1; end
    end
    if (gc) m_last = 0;
    if (gd || tmo) m_last = 1;
    hc = {hc[6:0], cpu_gnt};
    hd = {hd[6:0], dbg_gnt};
    chk("cpu_gnt", cpu_gnt, gc);
    chk("dbg_gnt", dbg_gnt, gd);
    g   = gc | gd;
    w   = gc ? cpu_p : dbg_p;
    leg = g && ref_legal(w.we, w.f3, w.addr);
    chk("mem_wr", mem_wr, leg && w.we);
    chk("mem_rd", mem_rd, leg && !w.we);
    chk("mem_bus", {mem_addr, mem_wdata, mem_funct3},
        g ? {w.addr, w.wd, w.f3} : 47'h0);
    if (g) begin
      e.cyc  = cyc;
      e.side = gd;
      e.err  = !leg;
      e.data = (leg && !w.we) ? ref_load(w.f3, w.addr) : 32'h0;
      exp_q.push_back(e);
      if (leg && w.we) ref_store(w.f3, w.addr, w.wd);
      if (gc) cpu_p.req = 0;
      else    dbg_p.req = 0;
    end
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    resp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("rvalid_side", {cpu_rvalid, dbg_rvalid}, {!e.side, e.side});
      chk("resp_err",   e.side ? dbg_err : cpu_err, e.err);
      chk("resp_rdata", e.side ? dbg_rdata : cpu_rdata, e.data);
    end else begin
      chk("no_resp", {cpu_rvalid, dbg_rvalid}, 2'b00);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive();
    cpu_req = cpu_p.req; cpu_we = cpu_p.we; cpu_funct3 = cpu_p.f3;
    cpu_addr = cpu_p.addr; cpu_wdata = cpu_p.wd;
    dbg_req = dbg_p.req; dbg_we = dbg_p.we; dbg_funct3 = dbg_p.f3;
    dbg_addr = dbg_p.addr; dbg_wdata = dbg_p.wd;
    dbg_lock = lock_in;
  endtask

  // One clock: inputs applied just after posedge, checked at negedge.
  task automatic step();
    drive();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic rq_t mk(bit we, bit [2:0] f3, bit [11:0] addr, bit [31:0] wd);
    rq_t r;
    r.req = 1; r.we = we; r.f3 = f3; r.addr = addr; r.wd = wd;
    return r;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((cpu_p.req || dbg_p.req) && n < 20) begin step(); n++; end
    chk(name, {cpu_p.req, dbg_p.req}, 2'b00);
  endtask

  task automatic issue(input bit side, input rq_t r);
    if (side) dbg_p = r; else cpu_p = r;
    drain("grant_timeout");
  endtask

  function automatic rq_t rand_rq();
    bit [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit [2:0] f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)]
                                               : 3'($urandom_range(0, 7));
    bit [11:0] a = 12'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 3) == 0) a = a + 12'($urandom_range(1, 3));
    return mk(1'($urandom_range(0, 1)), f3, a, $urandom);
  endfunction

  initial begin
    cpu_p = '{default: 0};
    dbg_p = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
    chk("rst_err",    {cpu_err, dbg_err}, 2'b00);
    chk("rst_rdata",  {cpu_rdata, dbg_rdata}, 64'h0);
    rst = 1'b0;

    // Loader preloads, then CPU lw 0x010 of 0xDEADBEEF.
    issue(1, mk(1, 3'd2, 12'h010, 32'hDEADBEEF));
    issue(1, mk(1, 3'd2, 12'h000, 32'hA5A5_5A5A));
    issue(0, mk(0, 3'd2, 12'h010, 0));
    chk("lw_gnt_hist", hc[0], 1'b1);
    chk("lw_rvalid", cpu_rvalid, 1'b1);
    chk("lw_rdata",  cpu_rdata, 32'hDEADBEEF);
    chk("lw_err",    cpu_err, 1'b0);

    // Round-robin: loader goes first so the CPU wins the first tie.
    issue(1, mk(0, 3'd2, 12'h004, 0));
    for (int k = 0; k < 4; k++) begin
      if (!cpu_p.req) cpu_p = mk(0, 3'd2, 12'(4 * k), 0);
      if (!dbg_p.req) dbg_p = mk(0, 3'd4, 12'(k), 0);
      step();
    end
    chk("alt_cpu", hc[3:0], 4'b1010);
    chk("alt_dbg", hd[3:0], 4'b0101);
    drain("alt_drain");

    // Misaligned sh is rejected and leaves memory intact.
    issue(0, mk(1, 3'd1, 12'h003, 32'hFFFF_FFFF));
    chk("sh_mis_err",   cpu_err, 1'b1);
    chk("sh_mis_rdata", cpu_rdata, 32'h0);
    issue(0, mk(0, 3'd2, 12'h000, 0));
    chk("lw0_rdata", cpu_rdata, 32'hA5A5_5A5A);

    // Lock: loader alone takes it, CPU joins; 4 loader grants then CPU.
    lock_in = 1;
    for (int k = 0; k < 5; k++) begin
      if (!dbg_p.req) dbg_p = mk(0, 3'd2, 12'h010, 0);
      if (k > 0 && !cpu_p.req) cpu_p = mk(0, 3'd2, 12'h000, 0);
      step();
    end
    chk("lock_dbg", hd[4:0], 5'b11110);
    chk("lock_cpu", hc[4:0], 5'b00001);
    lock_in = 0;
    drain("lock_drain");

    // Byte extraction after a loader word store.
    issue(1, mk(1, 3'd2, 12'h020, 32'h12345678));
    issue(0, mk(0, 3'd4, 12'h022, 0));
    chk("lbu_rdata", cpu_rdata, 32'h00000034);
    issue(0, mk(0, 3'd0, 12'h023, 0));
    chk("lb_rdata", cpu_rdata, 32'h00000012);

    // Reset in the response cycle of a load drops the response.
    issue(0, mk(0, 3'd2, 12'h010, 0));
    rst = 1'b1;
    exp_q.delete();
    m_last = 1; m_locked = 0; m_run = 0;
    drive();
    #1;
    chk("rst_mid_rvalid", cpu_rvalid, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_rvalid", cpu_rvalid, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_p = mk(0, 3'd2, 12'h000, 0);
    dbg_p = mk(0, 3'd2, 12'h004, 0);
    step();
    chk("tie_after_rst", {hc[0], hd[0]}, 2'b10);
    drain("rst_drain");

    // Random traffic with a slowly toggling lock.
    for (int k = 0; k < 3000; k++) begin
      if (!cpu_p.req && $urandom_range(0, 2) != 0) cpu_p = rand_rq();
      if (!dbg_p.req && $urandom_range(0, 2) != 0) dbg_p = rand_rq();
      if ($urandom_range(0, 7) == 0) lock_in = !lock_in;
      step();
    end
    lock_in = 0;
    drain("final_drain");
    step();
    @(negedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
